gestor_jugadas: RTL and testbench
=================================

Name: gestor_jugadas

Overview:
- Move-control stage of the tic-tac-toe datapath. It sits directly upstream of the nine per-cell output registers (registro0..registro8) and produces the 6-bit word each of them holds.
- Accepts a cell-select strobe from the input decoder and validates the move (range, occupancy).
- On a valid move it writes the cell word, counts moves, alternates turns, and detects win or draw.

Parameters:
- CODIGO_X, 2'b01, occupant code written for player X.
- CODIGO_O, 2'b10, occupant code written for player O.
- PRIMER_JUGADOR, 1'b0, player who moves first after reset or restart (0 = X, 1 = O).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- jugada  input  1  single-cycle move strobe.
- casilla  input  4  target cell index, 0..8, row-major (0 = top-left).
- reiniciar  input  1  synchronous new-game request, same effect as reset.
- registro0..registro8  output  6 each  cell word: [1:0] occupant (00 empty, else CODIGO_X or CODIGO_O); [5:2] move number 1..9 at which the cell was taken, 0 if empty.
- jugador  output  1  player whose turn it is (0 = X, 1 = O).
- listo  output  1  high only in state ESPERA.
- rechazo  output  1  one-cycle pulse on an invalid move.
- ganador  output  2  00 none, otherwise the winner's occupant code.
- empate  output  1  draw flag.
- num_jugadas  output  4  count of accepted moves, 0..9.

Behaviour:
- Reset or reiniciar sampled high at an edge, from any state:
  - all registroN = 6'd0, jugador = PRIMER_JUGADOR, num_jugadas = 0;
  - ganador = 00, empate = 0, rechazo = 0;
  - state = ESPERA.
- reset and reiniciar take priority over every other input in the same cycle.
- State ESPERA (listo = 1):
  - jugada = 1 with casilla <= 8 and registro[casilla][1:0] == 00 (valid move):
    - registro[casilla] <= {num_jugadas+1, code of jugador};
    - num_jugadas <= num_jugadas+1;
    - state -> EVALUA.
  - jugada = 1 with casilla > 8 (9..15) or the cell occupied:
    - rechazo = 1 on the next cycle only;
    - no state, cell, count or turn change; remain in ESPERA.
  - jugada = 0: hold.
- State EVALUA (listo = 0), exactly one cycle:
  - Check the 8 lines (rows 0-1-2, 3-4-5, 6-7-8; columns 0-3-6, 1-4-7, 2-5-8; diagonals 0-4-8, 2-4-6) on the registered cell values for the current jugador's code.
  - Win: ganador <= that code, state -> FIN; jugador does not toggle.
  - No win and num_jugadas == 9: empate <= 1, state -> FIN.
  - Otherwise: jugador toggles, state -> ESPERA.
  - A win on the 9th move sets ganador and leaves empate = 0.
- State FIN (listo = 0): holds all outputs. Exits only via reset or reiniciar.
- jugada while in EVALUA or FIN is ignored silently (no rechazo pulse).
- Latency:
  - cell word visible 1 cycle after the accepting edge;
  - ganador/empate/jugador toggle visible 2 cycles after it;
  - the next move can be accepted no earlier than 2 cycles after the previous accepted strobe.
- Only the current player's code is checked in EVALUA, because only that player can have just completed a line.
- num_jugadas never exceeds 9. The [5:2] field is 4 bits unsigned and holds 1..9.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then moves at cells 4, 0, 8 (each followed by 2 idle cycles):
  - registro4 = {4'd1, 01}, registro0 = {4'd2, 10}, registro8 = {4'd3, 01};
  - jugador = 1; num_jugadas = 3.
- Occupied cell: after a move at 4, strobe cell 4 again.
  - rechazo pulses for exactly 1 cycle; registro4, num_jugadas and jugador unchanged; listo stays 1.
- Out of range: strobe casilla = 9, then 15.
  - rechazo pulses each time; all cells remain 0.
- X wins on diagonal 2-4-6 via the sequence X2, O0, X4, O1, X6:
  - 2 cycles after the last strobe: ganador = 01, empate = 0, listo = 0, jugador = 0;
  - a following strobe at cell 3 is ignored, no rechazo.
- Full board with no line, sequence X0, O1, X2, O4, X3, O5, X7, O6, X8:
  - empate = 1, ganador = 00, num_jugadas = 9, registro8 = {4'd9, 01}.
- reiniciar asserted in the same cycle as a valid jugada during mid-game:
  - all cells = 0, num_jugadas = 0, jugador = PRIMER_JUGADOR, state ESPERA (listo = 1 next cycle);
  - the move is not recorded.

Source files
------------

// File: rtl/gestor_jugadas.sv
// gestor_jugadas: tic-tac-toe move control, validation, turn and result.
// Ports: clk, reset, jugada, casilla, reiniciar -> registro0..8, jugador, listo, rechazo, ganador, empate, num_jugadas.
module gestor_jugadas #(
  parameter logic [1:0] CODIGO_X = 2'b01,
  parameter logic [1:0] CODIGO_O = 2'b10,
  parameter logic PRIMER_JUGADOR = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       jugada,
  input  logic [3:0] casilla,
  input  logic       reiniciar,
  output logic [5:0] registro0,
  output logic [5:0] registro1,
  output logic [5:0] registro2,
  output logic [5:0] registro3,
  output logic [5:0] registro4,
  output logic [5:0] registro5,
  output logic [5:0] registro6,
  output logic [5:0] registro7,
  output logic [5:0] registro8,
  output logic       jugador,
  output logic       listo,
  output logic       rechazo,
  output logic [1:0] ganador,
  output logic       empate,
  output logic [3:0] num_jugadas
);

  typedef enum logic [1:0] {
    ESPERA = 2'd0,
    EVALUA = 2'd1,
    FIN    = 2'd2
  } estado_t;

  estado_t    estado;
  logic [5:0] celdas [9];

  logic [1:0] codigo;
  logic       sel_libre;
  logic       valida;
  logic       gana;
  logic [3:0] siguiente;
  logic [1:0] ocup [9];

  function automatic logic linea(
    input logic [1:0] a,
    input logic [1:0] b,
    input logic [1:0] c,
    input logic [1:0] k
  );
    return (a == k) && (b == k) && (c == k);
  endfunction

  assign codigo = jugador ? CODIGO_O : CODIGO_X;
  assign siguiente = num_jugadas + 4'd1;

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      ocup[i] = celdas[i][1:0];
    end
  end

  // Cell lookup by comparison so casilla 9..15 never indexes the array.
  always_comb begin
    sel_libre = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (casilla == 4'(i)) begin
        sel_libre = (ocup[i] == 2'b00);
      end
    end
  end

  assign valida = jugada && (casilla <= 4'd8) && sel_libre;

  // Only the player who just moved can have completed a line.
  always_comb begin
    gana = linea(ocup[0], ocup[1], ocup[2], codigo)
         | linea(ocup[3], ocup[4], ocup[5], codigo)
         | linea(ocup[6], ocup[7], ocup[8], codigo)
         | linea(ocup[0], ocup[3], ocup[6], codigo)
         | linea(ocup[1], ocup[4], ocup[7], codigo)
         | linea(ocup[2], ocup[5], ocup[8], codigo)
         | linea(ocup[0], ocup[4], ocup[8], codigo)
         | linea(ocup[2], ocup[4], ocup[6], codigo);
  end

  always_ff @(posedge clk) begin
    if (reset || reiniciar) begin
      for (int i = 0; i < 9; i++) begin
        celdas[i] <= 6'd0;
      end
      estado      <= ESPERA;
      jugador     <= PRIMER_JUGADOR;
      listo       <= 1'b1;
      rechazo     <= 1'b0;
      ganador     <= 2'b00;
      empate      <= 1'b0;
      num_jugadas <= 4'd0;
    end else begin
      rechazo <= 1'b0;
      unique case (estado)
        ESPERA: begin
          if (valida) begin
            for (int i = 0; i < 9; i++) begin
              if (casilla == 4'(i)) begin
                celdas[i] <= {siguiente, codigo};
              end
            end
            num_jugadas <= siguiente;
            estado      <= EVALUA;
            listo       <= 1'b0;
          end else if (jugada) begin
            rechazo <= 1'b1;
          end
        end
        EVALUA: begin
          if (gana) begin
            ganador <= codigo;
            estado  <= FIN;
          end else if (num_jugadas == 4'd9) begin
            empate <= 1'b1;
            estado <= FIN;
          end else begin
            jugador <= ~jugador;
            estado  <= ESPERA;
            listo   <= 1'b1;
          end
        end
        FIN: begin
          estado <= FIN;
        end
        default: begin
          estado <= ESPERA;
          listo  <= 1'b1;
        end
      endcase
    end
  end

  assign registro0 = celdas[0];
  assign registro1 = celdas[1];
  assign registro2 = celdas[2];
  assign registro3 = celdas[3];
  assign registro4 = celdas[4];
  assign registro5 = celdas[5];
  assign registro6 = celdas[6];
  assign registro7 = celdas[7];
  assign registro8 = celdas[8];

endmodule

// File: tb/tb_gestor_jugadas.sv
// tb_gestor_jugadas: directed bench for gestor_jugadas.
// Drives on negedge, samples on negedge, hand-computed expectations.
module tb_gestor_jugadas;

  logic       clk;
  logic       reset;
  logic       jugada;
  logic [3:0] casilla;
  logic       reiniciar;
  logic [5:0] registro0;
  logic [5:0] registro1;
  logic [5:0] registro2;
  logic [5:0] registro3;
  logic [5:0] registro4;
  logic [5:0] registro5;
  logic [5:0] registro6;
  logic [5:0] registro7;
  logic [5:0] registro8;
  logic       jugador;
  logic       listo;
  logic       rechazo;
  logic [1:0] ganador;
  logic       empate;
  logic [3:0] num_jugadas;

  int compared = 0;
  int mismatched = 0;

  gestor_jugadas dut (
    .clk(clk),
    .reset(reset),
    .jugada(jugada),
    .casilla(casilla),
    .reiniciar(reiniciar),
    .registro0(registro0),
    .registro1(registro1),
    .registro2(registro2),
    .registro3(registro3),
    .registro4(registro4),
    .registro5(registro5),
    .registro6(registro6),
    .registro7(registro7),
    .registro8(registro8),
    .jugador(jugador),
    .listo(listo),
    .rechazo(rechazo),
    .ganador(ganador),
    .empate(empate),
    .num_jugadas(num_jugadas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chequear(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic mover(input logic [3:0] c);
    @(negedge clk);
    jugada  = 1'b1;
    casilla = c;
    @(negedge clk);
    jugada = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic rechazar(input string tag, input logic [3:0] c);
    @(negedge clk);
    jugada  = 1'b1;
    casilla = c;
    @(negedge clk);
    jugada = 1'b0;
    chequear({tag, "_pulso"}, 32'(rechazo), 32'd1);
    chequear({tag, "_listo"}, 32'(listo), 32'd1);
    @(negedge clk);
    chequear({tag, "_fin"}, 32'(rechazo), 32'd0);
  endtask

  function automatic logic [53:0] tablero();
    return {registro8, registro7, registro6, registro5, registro4,
            registro3, registro2, registro1, registro0};
  endfunction

  initial begin
    reset = 1'b0;
    jugada = 1'b0;
    casilla = 4'd0;
    reiniciar = 1'b0;

    do_reset();
    chequear("rst_tablero", 32'(tablero() != 54'd0), 32'd0);
    chequear("rst_listo", 32'(listo), 32'd1);
    chequear("rst_jugador", 32'(jugador), 32'd0);
    chequear("rst_num", 32'(num_jugadas), 32'd0);
    chequear("rst_ganador", 32'(ganador), 32'd0);
    chequear("rst_empate", 32'(empate), 32'd0);
    chequear("rst_rechazo", 32'(rechazo), 32'd0);

    // Out-of-range cells on an empty board.
    rechazar("rango9", 4'd9);
    rechazar("rango15", 4'd15);
    chequear("rango_vacio", 32'(tablero() != 54'd0), 32'd0);
    chequear("rango_num", 32'(num_jugadas), 32'd0);

    // Basic moves 4, 0, 8.
    mover(4'd4);
    chequear("m4_reg4", 32'(registro4), 32'h05);
    chequear("m4_jug", 32'(jugador), 32'd1);
    mover(4'd0);
    chequear("m0_reg0", 32'(registro0), 32'h0A);
    mover(4'd8);
    chequear("m8_reg8", 32'(registro8), 32'h0D);
    chequear("m8_jug", 32'(jugador), 32'd1);
    chequear("m8_num", 32'(num_jugadas), 32'd3);

    // Occupied cell rejected, nothing changes.
    rechazar("ocup4", 4'd4);
    chequear("ocup_reg4", 32'(registro4), 32'h05);
    chequear("ocup_num", 32'(num_jugadas), 32'd3);
    chequear("ocup_jug", 32'(jugador), 32'd1);

    // New game with a valid move in the same cycle: move is dropped.
    @(negedge clk);
    jugada = 1'b1;
    casilla = 4'd3;
    reiniciar = 1'b1;
    @(negedge clk);
    jugada = 1'b0;
    reiniciar = 1'b0;
    chequear("rein_tablero", 32'(tablero() != 54'd0), 32'd0);
    chequear("rein_num", 32'(num_jugadas), 32'd0);
    chequear("rein_jug", 32'(jugador), 32'd0);
    chequear("rein_listo", 32'(listo), 32'd1);
    @(negedge clk);
    chequear("rein_reg3", 32'(registro3), 32'd0);

    // X wins on diagonal 2-4-6.
    mover(4'd2);
    mover(4'd0);
    mover(4'd4);
    chequear("dia_sin_gan", 32'(ganador), 32'd0);
    mover(4'd1);
    mover(4'd6);
    chequear("dia_ganador", 32'(ganador), 32'h1);
    chequear("dia_empate", 32'(empate), 32'd0);
    chequear("dia_listo", 32'(listo), 32'd0);
    chequear("dia_jug", 32'(jugador), 32'd0);
    chequear("dia_reg6", 32'(registro6), 32'h15);
    @(negedge clk);
    jugada = 1'b1;
    casilla = 4'd3;
    @(negedge clk);
    jugada = 1'b0;
    chequear("fin_rechazo", 32'(rechazo), 32'd0);
    chequear("fin_reg3", 32'(registro3), 32'd0);
    chequear("fin_num", 32'(num_jugadas), 32'd5);

    // Full board, no line: draw.
    do_reset();
    mover(4'd0);
    mover(4'd1);
    mover(4'd2);
    mover(4'd4);
    mover(4'd3);
    mover(4'd5);
    mover(4'd7);
    mover(4'd6);
    chequear("emp_previo", 32'(empate), 32'd0);
    mover(4'd8);
    chequear("emp_empate", 32'(empate), 32'd1);
    chequear("emp_ganador", 32'(ganador), 32'd0);
    chequear("emp_num", 32'(num_jugadas), 32'd9);
    chequear("emp_reg8", 32'(registro8), 32'h25);
    chequear("emp_reg6", 32'(registro6), 32'h22);
    chequear("emp_listo", 32'(listo), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
